// File: rtl/std_cache_pkg.sv
`default_nettype none
// ============================================================================
// Package : std_cache_pkg
// Desc    : Shared types and defaults for the std-cache request path.
// Rev     : 1.0 - initial release
// ============================================================================
package std_cache_pkg;

    localparam int unsigned C_MAX_PORTS               = 8;
    localparam int unsigned C_DEFAULT_MAX_OUTSTANDING = 4;

    // Sized for the largest supported requester count so one type serves every build.
    typedef logic [$clog2(C_MAX_PORTS)-1:0] port_id_t;

endpackage
`default_nettype wire

// File: rtl/dcache_id_fifo.sv
`default_nettype none
// ============================================================================
// Module : dcache_id_fifo
// Desc   : In-order FIFO of requester IDs for outstanding cache reads.
// Rev    : 1.0 - initial release
// ============================================================================
module dcache_id_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dcache_port_arbiter
// Desc   : Round-robin, lock-until-grant arbiter sharing one dcache request
//          port; read responses are steered back through an in-order ID FIFO.
// Rev    : 1.0 - initial release
// ============================================================================
module dcache_port_arbiter
    import std_cache_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = 3,
    parameter int unsigned ADDR_W          = 64,
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned MAX_OUTSTANDING = C_DEFAULT_MAX_OUTSTANDING
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_PORTS-1:0]            req_i,
    input  logic [NUM_PORTS-1:0]            we_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]     addr_i,
    input  logic [NUM_PORTS*DATA_W-1:0]     wdata_i,
    input  logic [NUM_PORTS*(DATA_W/8)-1:0] be_i,
    output logic [NUM_PORTS-1:0]            gnt_o,
    output logic [NUM_PORTS-1:0]            rvalid_o,
    output logic [DATA_W-1:0]               rdata_o,
    output logic                            cache_req_o,
    output logic                            cache_we_o,
    output logic [ADDR_W-1:0]               cache_addr_o,
    output logic [DATA_W-1:0]               cache_wdata_o,
    output logic [DATA_W/8-1:0]             cache_be_o,
    input  logic                            cache_gnt_i,
    input  logic                            cache_rvalid_i,
    input  logic [DATA_W-1:0]               cache_rdata_i,
    output logic                            err_o
);

    localparam int unsigned BE_W = DATA_W / 8;

    port_id_t          r_rr;
    port_id_t          r_sel;
    logic              r_lock;
    logic              r_err;
    port_id_t          w_sel;
    port_id_t          w_head;
    logic              w_sel_req;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [BE_W-1:0]   w_be;
    logic              w_full;
    logic              w_empty;
    logic              w_grant;
    logic              w_push;
    logic              w_pop;

    // First requesting port at or after start, wrapping around.
    function automatic port_id_t rr_pick(input logic [NUM_PORTS-1:0] req, input port_id_t start);
        logic found;
        rr_pick = start;
        found   = 1'b0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (!found && req[p] && (port_id_t'(p) >= start)) begin
                rr_pick = port_id_t'(p);
                found   = 1'b1;
            end
        end
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (!found && req[p]) begin
                rr_pick = port_id_t'(p);
                found   = 1'b1;
            end
        end
    endfunction

    assign w_sel = r_lock ? r_sel : rr_pick(req_i, r_rr);

    always_comb begin
        w_sel_req = 1'b0;
        w_we      = 1'b0;
        w_addr    = '0;
        w_wdata   = '0;
        w_be      = '0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (w_sel == port_id_t'(p)) begin
                w_sel_req = req_i[p];
                w_we      = we_i[p];
                w_addr    = addr_i[p*ADDR_W +: ADDR_W];
                w_wdata   = wdata_i[p*DATA_W +: DATA_W];
                w_be      = be_i[p*BE_W +: BE_W];
            end
        end
    end

    // A locked request stays asserted even if the requester misbehaves, so the lock can retire.
    assign cache_req_o   = ~rst_i & (r_lock | (|req_i)) & ~w_full;
    assign cache_we_o    = cache_req_o & w_we;
    assign cache_addr_o  = cache_req_o ? w_addr  : '0;
    assign cache_wdata_o = cache_req_o ? w_wdata : '0;
    assign cache_be_o    = cache_req_o ? w_be    : '0;

    assign w_grant = cache_req_o & cache_gnt_i;
    assign w_push  = w_grant & ~w_we;
    assign w_pop   = ~rst_i & cache_rvalid_i & ~w_empty;
    assign rdata_o = w_pop ? cache_rdata_i : '0;
    assign err_o   = r_err;

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            gnt_o[p]    = w_grant & (w_sel == port_id_t'(p));
            rvalid_o[p] = w_pop & (w_head == port_id_t'(p));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr   <= '0;
            r_sel  <= '0;
            r_lock <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_grant) begin
                r_rr   <= (w_sel == port_id_t'(NUM_PORTS - 1)) ? '0 : w_sel + port_id_t'(1);
                r_lock <= 1'b0;
            end else if (cache_req_o) begin
                r_lock <= 1'b1;
                r_sel  <= w_sel;
            end
            if ((r_lock && !w_sel_req) || (cache_rvalid_i && w_empty)) begin
                r_err <= 1'b1;
            end
        end
    end

    dcache_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH ($bits(port_id_t))
    ) u_id_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_sel),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_dcache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_dcache_port_arbiter
// Desc   : Directed self-checking bench for dcache_port_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_dcache_port_arbiter;

    localparam int unsigned NP = 3;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned BW = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     req;
    logic [NP-1:0]     we;
    logic [NP*AW-1:0]  addr;
    logic [NP*DW-1:0]  wdata;
    logic [NP*BW-1:0]  be;
    logic [NP-1:0]     gnt;
    logic [NP-1:0]     rvalid;
    logic [DW-1:0]     rdata;
    logic              c_req;
    logic              c_we;
    logic [AW-1:0]     c_addr;
    logic [DW-1:0]     c_wdata;
    logic [BW-1:0]     c_be;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DW-1:0]     c_rdata;
    logic              err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dcache_port_arbiter #(
        .NUM_PORTS       (NP),
        .ADDR_W          (AW),
        .DATA_W          (DW),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req),
        .we_i           (we),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .be_i           (be),
        .gnt_o          (gnt),
        .rvalid_o       (rvalid),
        .rdata_o        (rdata),
        .cache_req_o    (c_req),
        .cache_we_o     (c_we),
        .cache_addr_o   (c_addr),
        .cache_wdata_o  (c_wdata),
        .cache_be_o     (c_be),
        .cache_gnt_i    (c_gnt),
        .cache_rvalid_i (c_rvalid),
        .cache_rdata_i  (c_rdata),
        .err_o          (err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] exp_rv [4];
        exp_rv[0] = 3'b001; exp_rv[1] = 3'b010; exp_rv[2] = 3'b001; exp_rv[3] = 3'b100;

        rst      = 1'b1;
        req      = '0;
        we       = '0;
        wdata    = '0;
        be       = '1;
        c_gnt    = 1'b0;
        c_rvalid = 1'b0;
        c_rdata  = '0;
        addr     = '0;
        addr[0*AW +: AW] = 64'h0A00;
        addr[1*AW +: AW] = 64'h1000;
        addr[2*AW +: AW] = 64'h2200;
        cyc();
        cyc();

        // Reset state
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_rvalid", 64'(rvalid), 64'h0);
        chk("rst_req", 64'(c_req), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_rdata", rdata, 64'h0);
        rst = 1'b0;
        cyc();

        // Fairness with writes
        req = 3'b111; we = 3'b111; c_gnt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("fair_gnt%0d", i), 64'(gnt), 64'(3'b001 << (i % 3)));
            cyc();
        end
        req = '0; c_gnt = 1'b0;

        // Single read on port1
        req = 3'b010; we = 3'b000; c_gnt = 1'b1;
        #1;
        chk("rd_gnt", 64'(gnt), 64'h2);
        chk("rd_addr", c_addr, 64'h1000);
        chk("rd_we", 64'(c_we), 64'h0);
        cyc();
        req = '0; c_gnt = 1'b0;
        cyc();
        cyc();
        c_rvalid = 1'b1; c_rdata = 64'hDEAD;
        #1;
        chk("rd_rvalid", 64'(rvalid), 64'h2);
        chk("rd_rdata", rdata, 64'hDEAD);
        chk("rd_err", 64'(err), 64'h0);
        cyc();
        c_rvalid = 1'b0;

        // Move pointer from 2 to 0 with a port2 write
        req = 3'b100; we = 3'b100; c_gnt = 1'b1;
        #1;
        chk("pre_lock_gnt", 64'(gnt), 64'h4);
        cyc();

        // Lock: port2 waits four cycles while port0 joins
        c_gnt = 1'b0; req = 3'b100; we = 3'b101;
        #1;
        chk("lock_addr0", c_addr, 64'h2200);
        chk("lock_gnt0", 64'(gnt), 64'h0);
        cyc();
        for (int i = 1; i < 4; i++) begin
            req = 3'b101;
            #1;
            chk($sformatf("lock_addr%0d", i), c_addr, 64'h2200);
            chk($sformatf("lock_gnt%0d", i), 64'(gnt), 64'h0);
            cyc();
        end
        c_gnt = 1'b1;
        #1;
        chk("lock_gnt_p2", 64'(gnt), 64'h4);
        cyc();
        req = 3'b001;
        #1;
        chk("lock_gnt_p0", 64'(gnt), 64'h1);
        chk("lock_addr_p0", c_addr, 64'h0A00);
        cyc();
        req = '0; c_gnt = 1'b0;
        #1;
        chk("lock_err", 64'(err), 64'h0);

        // Fill the ID FIFO with reads from ports 0,1,0,2
        we = 3'b000; c_gnt = 1'b1;
        req = 3'b001; #1; chk("full_g0", 64'(gnt), 64'h1); cyc();
        req = 3'b010; #1; chk("full_g1", 64'(gnt), 64'h2); cyc();
        req = 3'b001; #1; chk("full_g2", 64'(gnt), 64'h1); cyc();
        req = 3'b100; #1; chk("full_g3", 64'(gnt), 64'h4); cyc();
        req = 3'b010;
        #1;
        chk("full_req", 64'(c_req), 64'h0);
        chk("full_gnt", 64'(gnt), 64'h0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            c_rvalid = 1'b1; c_rdata = 64'(32'h1111 * (i + 1));
            #1;
            chk($sformatf("ord_rv%0d", i), 64'(rvalid), 64'(exp_rv[i]));
            chk($sformatf("ord_rd%0d", i), rdata, 64'(32'h1111 * (i + 1)));
            if (i == 0) chk("full_pop_req", 64'(c_req), 64'h0);
            cyc();
            req = '0;
        end
        c_rvalid = 1'b0;
        req = 3'b010;
        #1;
        chk("fifth_req", 64'(c_req), 64'h1);
        chk("fifth_gnt", 64'(gnt), 64'h2);
        cyc();
        req = '0; c_gnt = 1'b0;
        c_rvalid = 1'b1; c_rdata = 64'h5555;
        #1;
        chk("fifth_rv", 64'(rvalid), 64'h2);
        cyc();

        // Response with nothing outstanding
        #1;
        chk("empty_rv", 64'(rvalid), 64'h0);
        chk("empty_err_pre", 64'(err), 64'h0);
        cyc();
        c_rvalid = 1'b0;
        #1;
        chk("empty_err", 64'(err), 64'h1);
        cyc();
        chk("err_sticky", 64'(err), 64'h1);

        // Leave one read outstanding, lock port0, then reset mid-lock
        req = 3'b010; we = 3'b000; c_gnt = 1'b1;
        #1;
        chk("pre_rst_gnt", 64'(gnt), 64'h2);
        cyc();
        req = 3'b001; c_gnt = 1'b0;
        cyc();
        rst = 1'b1; c_gnt = 1'b1;
        #1;
        chk("mid_rst_req", 64'(c_req), 64'h0);
        chk("mid_rst_gnt", 64'(gnt), 64'h0);
        chk("mid_rst_err", 64'(err), 64'h0);
        chk("mid_rst_rv", 64'(rvalid), 64'h0);
        cyc();
        rst = 1'b0;
        req = 3'b111; we = 3'b111;
        #1;
        chk("post_rst_g0", 64'(gnt), 64'h1);
        cyc();
        chk("post_rst_g1", 64'(gnt), 64'h2);
        cyc();
        req = '0; c_gnt = 1'b0;
        c_rvalid = 1'b1; c_rdata = 64'hBEEF;
        #1;
        chk("post_rst_rv", 64'(rvalid), 64'h0);
        cyc();
        c_rvalid = 1'b0;
        #1;
        chk("post_rst_err", 64'(err), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
